// File: rtl/change_dispenser_if.sv
// Payout request/result bundle between the vending controller and the change dispenser.
interface change_dispenser_if;
  logic       pay_valid;
  logic [5:0] pay_amount;
  logic       pay_ready;
  logic [5:0] paid_total;
  logic       pay_done;
  logic       pay_short;
  logic [5:0] short_amount;

  modport master (
    output pay_valid,
    output pay_amount,
    input  pay_ready,
    input  paid_total,
    input  pay_done,
    input  pay_short,
    input  short_amount
  );

  modport slave (
    input  pay_valid,
    input  pay_amount,
    output pay_ready,
    output paid_total,
    output pay_done,
    output pay_short,
    output short_amount
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays a latched amount greedily from four coin hoppers (10/5/2/1),
// confirming every coin with the exit sensor and declaring a jam when the ack times out.
module change_dispenser #(
  parameter int INV_W       = 8,
  parameter int INIT_INV    = 20,
  parameter int ACK_TIMEOUT = 16,
  parameter int LOW_MARK    = 2
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   pay_if,
  output logic [3:0]          o_eject,
  input  logic                i_eject_ack,
  input  logic                i_load_en,
  input  logic [1:0]          i_load_sel,
  input  logic [INV_W-1:0]    i_load_count,
  output logic                o_jam,
  input  logic                i_jam_clr,
  output logic [3:0]          o_inv_low
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_EJECT    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_JAM      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [INV_W-1:0] r_inv [4];
  logic [5:0]       r_remaining;
  logic [5:0]       r_paid_total;
  logic [5:0]       r_short_amount;
  logic [1:0]       r_sel;
  logic [7:0]       r_timer;
  logic             r_pay_ready;
  logic             r_pay_done;
  logic             r_pay_short;
  logic             r_jam;
  logic [3:0]       r_eject;
  logic             w_pick_found;
  logic [1:0]       w_pick_idx;
  logic             w_accept;
  logic             w_ack_hit;
  logic             w_timeout;

  function automatic logic [5:0] denom_value(input logic [1:0] idx);
    case (idx)
      2'd0:    denom_value = 6'd1;
      2'd1:    denom_value = 6'd2;
      2'd2:    denom_value = 6'd5;
      2'd3:    denom_value = 6'd10;
      default: denom_value = 6'd1;
    endcase
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && pay_if.pay_valid;
  assign w_ack_hit = (r_state == S_WAIT_ACK) && i_eject_ack;
  assign w_timeout = (r_timer == 8'(ACK_TIMEOUT - 1));

  // Greedy pick: largest stocked denomination that still fits the remainder.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!w_pick_found && (denom_value(2'(i)) <= r_remaining) && (r_inv[i] != '0)) begin
        w_pick_found = 1'b1;
        w_pick_idx   = 2'(i);
      end else begin
        w_pick_found = w_pick_found;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (pay_if.pay_valid) begin
          w_next_state = S_SELECT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SELECT: begin
        if (r_remaining == 6'd0) begin
          w_next_state = S_DONE;
        end else if (w_pick_found) begin
          w_next_state = S_EJECT;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_EJECT: begin
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A coin seen on the final timer cycle still counts as delivered.
        if (i_eject_ack) begin
          w_next_state = S_SELECT;
        end else if (w_timeout) begin
          w_next_state = S_JAM;
        end else begin
          w_next_state = S_WAIT_ACK;
        end
      end
      S_JAM: begin
        if (i_jam_clr) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_JAM;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // A load in the same IDLE cycle as an accept lands before SELECT inspects stock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_inv[i] <= INV_W'(INIT_INV);
      end
    end else if ((r_state == S_IDLE) && i_load_en) begin
      r_inv[i_load_sel] <= i_load_count;
    end else if (r_state == S_EJECT) begin
      r_inv[r_sel] <= r_inv[r_sel] - INV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining  <= 6'd0;
      r_paid_total <= 6'd0;
    end else if (w_accept) begin
      r_remaining  <= pay_if.pay_amount;
      r_paid_total <= 6'd0;
    end else if (w_ack_hit) begin
      r_remaining  <= r_remaining - denom_value(r_sel);
      r_paid_total <= r_paid_total + denom_value(r_sel);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel   <= 2'd0;
      r_timer <= 8'd0;
    end else if (r_state == S_SELECT) begin
      r_sel   <= w_pick_idx;
      r_timer <= 8'd0;
    end else if ((r_state == S_EJECT) || (r_state == S_WAIT_ACK)) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pay_short    <= 1'b0;
      r_short_amount <= 6'd0;
    end else if (w_accept) begin
      r_pay_short    <= 1'b0;
      r_short_amount <= 6'd0;
    end else if ((w_next_state == S_DONE) && (r_state != S_DONE)) begin
      r_pay_short    <= (r_remaining != 6'd0);
      r_short_amount <= r_remaining;
    end
  end

  // Status strobes are registered from the next state so they line up with that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pay_ready <= 1'b1;
      r_pay_done  <= 1'b0;
      r_jam       <= 1'b0;
      r_eject     <= 4'd0;
    end else begin
      r_pay_ready <= (w_next_state == S_IDLE);
      r_pay_done  <= (w_next_state == S_DONE);
      r_jam       <= (w_next_state == S_JAM);
      r_eject     <= (w_next_state == S_EJECT) ? onehot4(w_pick_idx) : 4'd0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      o_inv_low[i] = (r_inv[i] < INV_W'(LOW_MARK));
    end
  end

  assign pay_if.pay_ready    = r_pay_ready;
  assign pay_if.paid_total   = r_paid_total;
  assign pay_if.pay_done     = r_pay_done;
  assign pay_if.pay_short    = r_pay_short;
  assign pay_if.short_amount = r_short_amount;
  assign o_eject             = r_eject;
  assign o_jam               = r_jam;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised bench for change_dispenser against a greedy payout reference model.
`timescale 1ns/1ps
module tb_change_dispenser;
  localparam int INV_W       = 8;
  localparam int INIT_INV    = 20;
  localparam int ACK_TIMEOUT = 16;
  localparam int LOW_MARK    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       eject;
  logic             eject_ack = 1'b0;
  logic             load_en = 1'b0;
  logic [1:0]       load_sel = 2'd0;
  logic [INV_W-1:0] load_count = '0;
  logic             jam;
  logic             jam_clr = 1'b0;
  logic [3:0]       inv_low;

  change_dispenser_if pay_if();

  change_dispenser #(
    .INV_W(INV_W), .INIT_INV(INIT_INV), .ACK_TIMEOUT(ACK_TIMEOUT), .LOW_MARK(LOW_MARK)
  ) dut (
    .clk(clk), .reset(reset), .pay_if(pay_if),
    .o_eject(eject), .i_eject_ack(eject_ack),
    .i_load_en(load_en), .i_load_sel(load_sel), .i_load_count(load_count),
    .o_jam(jam), .i_jam_clr(jam_clr), .o_inv_low(inv_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int m_inv[4];
  int exp_coins[$];
  int exp_paid;
  int exp_short;
  bit exp_jam;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dval(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  task automatic model_pay(input int amt, input bit never_ack);
    int rem;
    int pick;
    rem = amt;
    exp_coins.delete();
    exp_paid = 0;
    exp_jam = 1'b0;
    while (rem > 0) begin
      pick = -1;
      for (int i = 3; i >= 0; i--)
        if (pick < 0 && dval(i) <= rem && m_inv[i] > 0) pick = i;
      if (pick < 0) break;
      exp_coins.push_back(dval(pick));
      m_inv[pick]--;
      if (never_ack) begin
        exp_jam = 1'b1;
        break;
      end
      rem -= dval(pick);
      exp_paid += dval(pick);
    end
    exp_short = rem;
  endtask

  task automatic check_inventory(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s inv%0d", tag, i), int'(dut.r_inv[i]), m_inv[i]);
      check_eq($sformatf("%s low%0d", tag, i), int'(inv_low[i]), (m_inv[i] < LOW_MARK) ? 1 : 0);
    end
  endtask

  task automatic load_hopper(input int sel, input int cnt);
    @(negedge clk);
    load_en = 1'b1;
    load_sel = 2'(sel);
    load_count = INV_W'(cnt);
    m_inv[sel] = cnt;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // delay = cycles from eject pulse to ack; 0 means the ack never comes.
  task automatic run_request(input int amt, input int delay, input bit hold,
                             input bit do_load, input int lsel, input int lcnt,
                             input string tag);
    int obs_coins[$];
    int t_acc, done_cyc, jam_cyc, ej_cyc, cd, n, ncoin;
    bit done, ack_drv;
    int obs_paid, obs_pshort, obs_short;
    done_cyc = -1; jam_cyc = -1; ej_cyc = -1; cd = 0; n = 0; done = 1'b0;
    obs_paid = 0; obs_pshort = 0; obs_short = 0;
    @(negedge clk);
    check_eq({tag, " ready"}, int'(pay_if.pay_ready), 1);
    if (do_load) begin
      load_en = 1'b1;
      load_sel = 2'(lsel);
      load_count = INV_W'(lcnt);
      m_inv[lsel] = lcnt;
    end
    pay_if.pay_valid = 1'b1;
    pay_if.pay_amount = 6'(amt);
    t_acc = cyc;
    model_pay(amt, delay == 0);
    @(negedge clk);
    load_en = 1'b0;
    if (hold) pay_if.pay_amount = 6'(amt) ^ 6'h15;
    else pay_if.pay_valid = 1'b0;
    check_eq({tag, " busy"}, int'(pay_if.pay_ready), 0);
    while (!done && n < 2000) begin
      ack_drv = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) ack_drv = 1'b1;
      end
      if (eject != 4'd0) begin
        check_eq({tag, " onehot"}, $countones(eject), 1);
        obs_coins.push_back(eject[3] ? 10 : eject[2] ? 5 : eject[1] ? 2 : 1);
        ej_cyc = cyc;
        if (delay > 0) cd = delay;
      end
      eject_ack = ack_drv;
      jam_clr = 1'b0;
      if (jam && jam_cyc < 0) begin
        jam_cyc = cyc;
        check_eq({tag, " jam_ready"}, int'(pay_if.pay_ready), 0);
        jam_clr = 1'b1;
      end
      if (pay_if.pay_done) begin
        done = 1'b1;
        done_cyc = cyc;
        obs_paid = int'(pay_if.paid_total);
        obs_pshort = int'(pay_if.pay_short);
        obs_short = int'(pay_if.short_amount);
        pay_if.pay_valid = 1'b0;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    eject_ack = 1'b0;
    jam_clr = 1'b0;
    check_eq({tag, " done"}, int'(done), 1);
    check_eq({tag, " paid"}, obs_paid, exp_paid);
    check_eq({tag, " short_flag"}, obs_pshort, (exp_short != 0) ? 1 : 0);
    check_eq({tag, " short_amt"}, obs_short, exp_short);
    check_eq({tag, " coins"}, obs_coins.size(), exp_coins.size());
    ncoin = (obs_coins.size() < exp_coins.size()) ? obs_coins.size() : exp_coins.size();
    for (int i = 0; i < ncoin; i++)
      check_eq($sformatf("%s coin%0d", tag, i), obs_coins[i], exp_coins[i]);
    check_eq({tag, " jam_seen"}, (jam_cyc >= 0) ? 1 : 0, int'(exp_jam));
    if (exp_jam) begin
      check_eq({tag, " jam_delay"}, jam_cyc - ej_cyc, ACK_TIMEOUT);
      check_eq({tag, " clr_to_done"}, done_cyc - jam_cyc, 1);
    end else begin
      check_eq({tag, " latency"}, done_cyc - t_acc, 2 + exp_coins.size() * (delay + 2));
    end
    check_inventory(tag);
    @(negedge clk);
    check_eq({tag, " done_pulse"}, int'(pay_if.pay_done), 0);
    check_eq({tag, " idle_ready"}, int'(pay_if.pay_ready), 1);
    check_eq({tag, " jam_clear"}, int'(jam), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " ready"}, int'(pay_if.pay_ready), 1);
    check_eq({tag, " eject"}, int'(eject), 0);
    check_eq({tag, " paid"}, int'(pay_if.paid_total), 0);
    check_eq({tag, " done"}, int'(pay_if.pay_done), 0);
    check_eq({tag, " short_flag"}, int'(pay_if.pay_short), 0);
    check_eq({tag, " short_amt"}, int'(pay_if.short_amount), 0);
    check_eq({tag, " jam"}, int'(jam), 0);
    check_inventory(tag);
  endtask

  initial begin
    int n;
    int amt, dly, sel, cnt;
    bit hold, dload;
    pay_if.pay_valid = 1'b0;
    pay_if.pay_amount = 6'd0;
    for (int i = 0; i < 4; i++) m_inv[i] = INIT_INV;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run_request(13, 1, 1'b0, 1'b0, 0, 0, "greedy13");
    load_hopper(3, 0);
    load_hopper(2, 0);
    run_request(15, 1, 1'b0, 1'b0, 0, 0, "twos15");
    load_hopper(1, 0);
    run_request(7, 2, 1'b0, 1'b1, 0, 3, "short7");
    load_hopper(3, 20);
    run_request(10, 0, 1'b0, 1'b0, 0, 0, "jam10");
    run_request(0, 1, 1'b0, 1'b0, 0, 0, "zero");
    load_hopper(1, 10);
    load_hopper(0, 10);
    run_request(3, 1, 1'b1, 1'b0, 0, 0, "hold3");

    // Reset while waiting for an ack.
    @(negedge clk);
    pay_if.pay_valid = 1'b1;
    pay_if.pay_amount = 6'd10;
    @(negedge clk);
    pay_if.pay_valid = 1'b0;
    n = 0;
    while (eject == 4'd0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst eject_seen", int'(eject[3]), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) m_inv[i] = INIT_INV;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    eject_ack = 1'b1;
    @(negedge clk);
    eject_ack = 1'b0;
    @(negedge clk);
    check_reset_outputs("stray_ack");

    for (int k = 0; k < 40; k++) begin
      amt = $urandom_range(0, 63);
      dly = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) dly = 0;
      hold = ($urandom_range(0, 3) == 0);
      dload = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 3);
      cnt = $urandom_range(0, 25);
      run_request(amt, dly, hold, dload, sel, cnt, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
